// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between the PS/2 host transmitter and its client.
// The client is the master; the transmitter is the slave.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (output tx_valid, tx_data, input tx_ready, busy, done, err);
    modport slave  (input tx_valid, tx_data, output tx_ready, busy, done, err);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, 8 data bits,
// odd parity, stop, device ACK and overall timeout on open-drain lines.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave tx,
    inout  wire          PS2_CLK,
    inout  wire          PS2_DATA
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             data_oe_q, data_oe_d;
    logic [9:0]       frame_q;
    logic             clk_s1_q, clk_s2_q, clk_prev_q;
    logic             dat_s1_q, dat_s2_q;
    logic             fall, accept, timeout;
    logic             clk_oe, dat_oe, done_d, err_d;

    assign accept  = tx.tx_valid && (state_q == S_IDLE);
    assign fall    = clk_prev_q & ~clk_s2_q;
    assign timeout = (tmo_cnt_q >= TMO_MAX);

    // Synchronisers reset to the idle-high bus level so no false edge follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            inh_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            bit_idx_q  <= '0;
            data_oe_q  <= 1'b0;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            inh_cnt_q  <= inh_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_oe_q  <= data_oe_d;
            clk_s1_q   <= PS2_CLK;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= PS2_DATA;
            dat_s2_q   <= dat_s1_q;
        end
    end

    // Frame layout, index 0 first on the wire: data LSB..MSB, odd parity, stop.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_q <= {1'b1, ~^tx.tx_data, tx.tx_data};
        end
    end

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        bit_idx_d = bit_idx_q;
        data_oe_d = data_oe_q;
        clk_oe    = 1'b0;
        dat_oe    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (accept) begin
                    state_d   = S_INHIBIT;
                    inh_cnt_d = '0;
                    bit_idx_d = '0;
                end
            end
            S_INHIBIT: begin
                clk_oe = 1'b1;
                if (inh_cnt_q == INH_LAST) begin
                    state_d = S_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            S_RTS: begin
                clk_oe    = 1'b1;
                dat_oe    = 1'b1;
                data_oe_d = 1'b1;
                tmo_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                if (timeout) begin
                    err_d     = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (state_q == S_SHIFT) begin
                        dat_oe = data_oe_q;
                        if (fall) begin
                            data_oe_d = ~frame_q[bit_idx_q];
                            bit_idx_d = bit_idx_q + 1'b1;
                            if (bit_idx_q == 4'd9) begin
                                state_d = S_ACK;
                            end
                        end
                    end else if (state_q == S_ACK) begin
                        if (fall) begin
                            if (!dat_s2_q) begin
                                state_d = S_WAIT_IDLE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                    end else if (clk_s2_q && dat_s2_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line enables decode straight from state so async reset releases them at once.
    assign PS2_CLK     = clk_oe ? 1'b0 : 1'bz;
    assign PS2_DATA    = dat_oe ? 1'b0 : 1'bz;
    assign tx.tx_ready = (state_q == S_IDLE);
    assign tx.busy     = (state_q != S_IDLE);
    assign tx.done     = done_d;
    assign tx.err      = err_d;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT and
// compares each sampled bit against a scoreboard filled when the byte is sent.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 200;
    localparam int TMO  = 5000;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    wire  ps2_clk;
    wire  ps2_data;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    logic sb_q[$];

    ps2_host_tx_if bus();

    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_data = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .tx      (bus),
        .PS2_CLK (ps2_clk),
        .PS2_DATA(ps2_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.err) err_cnt++;
        if (bus.done && bus.err) both_cnt++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) sb_q.push_back(b[i]);
        sb_q.push_back(~^b);
        sb_q.push_back(1'b1);
    endtask

    // Measure the inhibit + RTS low period; returns at the first negedge after clock release.
    task automatic dev_rts();
        int   lows = 0;
        logic last_dat = 1'b1;
        @(negedge clk);
        check_eq("busy_in_frame", bus.busy, 1);
        check_eq("ready_in_frame", bus.tx_ready, 0);
        while (ps2_clk === 1'b0 && lows < INH + 50) begin
            last_dat = ps2_data;
            lows++;
            @(negedge clk);
        end
        check_eq("inhibit_len", lows, INH + 1);
        check_eq("start_bit", last_dat, 0);
    endtask

    task automatic dev_bits(input int nfalls);
        logic exp;
        for (int i = 0; i < nfalls; i++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (sb_q.size() == 0) begin
                check_eq("scoreboard_empty", 1, 0);
            end else begin
                exp = sb_q.pop_front();
                check_eq($sformatf("frame_bit%0d", i), ps2_data, exp);
            end
        end
    endtask

    task automatic dev_ack(input bit ack_ok);
        repeat (HALF) @(negedge clk);
        if (ack_ok) dev_dat_low = 1'b1;
        repeat (4) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic full_frame(input logic [7:0] b, input bit ack_ok);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b);
        dev_rts();
        dev_bits(10);
        dev_ack(ack_ok);
        check_eq("done_pulses", done_cnt - d0, ack_ok ? 1 : 0);
        check_eq("err_pulses", err_cnt - e0, ack_ok ? 0 : 1);
        check_eq("ready_after", bus.tx_ready, 1);
        check_eq("clk_line_idle", ps2_clk, 1);
        check_eq("data_line_idle", ps2_data, 1);
    endtask

    initial begin
        int d0, e0, k;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", bus.tx_ready, 1);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_err", bus.err, 0);
        check_eq("rst_clk_line", ps2_clk, 1);
        check_eq("rst_data_line", ps2_data, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        full_frame(8'hED, 1'b1);
        full_frame(8'hF4, 1'b1);
        full_frame(8'hA5, 1'b0);

        // No device clocking after RTS: the DUT must give up on its own.
        e0 = err_cnt;
        d0 = done_cnt;
        send(8'hED);
        dev_rts();
        k = 0;
        while (!bus.err && k < TMO + 1000) begin
            @(negedge clk);
            k++;
        end
        check_eq("timeout_cycles", k, TMO);
        check_eq("timeout_clk_line", ps2_clk, 1);
        check_eq("timeout_data_line", ps2_data, 1);
        @(negedge clk);
        check_eq("timeout_ready", bus.tx_ready, 1);
        check_eq("timeout_err_pulses", err_cnt - e0, 1);
        check_eq("timeout_done_pulses", done_cnt - d0, 0);
        sb_q.delete();

        // Reset mid-frame while the DUT is actively pulling data low.
        e0 = err_cnt;
        d0 = done_cnt;
        send(8'h00);
        dev_rts();
        dev_bits(4);
        repeat (5) @(negedge clk);
        check_eq("pre_rst_data_driven", ps2_data, 0);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_data_line", ps2_data, 1);
        check_eq("rst_mid_clk_line", ps2_clk, 1);
        check_eq("rst_mid_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_mid_no_done", done_cnt - d0, 0);
        check_eq("rst_mid_no_err", err_cnt - e0, 0);
        sb_q.delete();
        full_frame(8'hED, 1'b1);

        // A request while busy must be dropped, not queued.
        d0 = done_cnt;
        fork
            full_frame(8'hED, 1'b1);
            begin
                repeat (INH + 150) @(negedge clk);
                check_eq("busy_reject_ready", bus.tx_ready, 0);
                bus.tx_valid = 1'b1;
                bus.tx_data  = 8'h55;
                @(negedge clk);
                bus.tx_valid = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check_eq("ignored_no_new_frame", bus.busy, 0);
        check_eq("ignored_done_once", done_cnt - d0, 1);
        check_eq("done_err_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
